// File: rtl/gpio_bank.sv
// Multi-channel memory-mapped GPIO: per-channel input capture with valid/overrun
// flags, registered outputs, status/mask registers and a registered level irq.
module gpio_bank #(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           CHANNELS  = 4,
  parameter int unsigned           ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = 8'hF0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS*DATA_W-1:0]   gpi,
  input  logic [CHANNELS-1:0]          gpi_we,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic [CHANNELS*DATA_W-1:0]   gpo,
  output logic                         irq
);

  localparam int unsigned       C          = CHANNELS;
  localparam logic [ADDR_W-1:0] STATUS_OFF = ADDR_W'(2 * C);
  localparam logic [ADDR_W-1:0] MASK_OFF   = ADDR_W'(2 * C + 1);

  logic [C-1:0][DATA_W-1:0] in_data;
  logic [C-1:0][DATA_W-1:0] out_data;
  logic [C-1:0][DATA_W-1:0] gpi_ch;
  logic [C-1:0]             valid, valid_nxt;
  logic [C-1:0]             overrun, overrun_nxt;
  logic [C-1:0]             mask;
  logic [C-1:0]             rd_in_hit;
  logic [C-1:0]             wr_out_hit;

  logic [ADDR_W:0]          diff;
  logic [ADDR_W-1:0]        offset;
  logic                     in_window;
  logic                     rd_hit;
  logic                     status_wr;
  logic                     mask_wr;
  logic [DATA_W-1:0]        status_word;
  logic [DATA_W-1:0]        mask_word;
  logic [DATA_W-1:0]        rd_mux;

  assign gpi_ch = gpi;
  assign gpo    = out_data;

  // Extra borrow bit so addresses below BASE_ADDR never wrap into the window.
  assign diff      = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign offset    = diff[ADDR_W-1:0];
  assign in_window = !diff[ADDR_W] && (offset <= MASK_OFF);

  assign rd_hit    = rd_en && in_window;
  assign status_wr = wr_en && in_window && (offset == STATUS_OFF);
  assign mask_wr   = wr_en && in_window && (offset == MASK_OFF);

  always_comb begin
    rd_in_hit  = '0;
    wr_out_hit = '0;
    for (int unsigned k = 0; k < C; k++) begin
      rd_in_hit[k]  = rd_hit && (offset == ADDR_W'(k));
      wr_out_hit[k] = wr_en && in_window && (offset == ADDR_W'(C + k));
    end
  end

  // Capture beats a same-cycle read; a new overrun beats a same-cycle W1C.
  always_comb begin
    valid_nxt   = valid;
    overrun_nxt = overrun;
    for (int unsigned k = 0; k < C; k++) begin
      if (rd_in_hit[k])
        valid_nxt[k] = 1'b0;
      if (gpi_we[k])
        valid_nxt[k] = 1'b1;
      if (status_wr && wr_data[C + k])
        overrun_nxt[k] = 1'b0;
      if (gpi_we[k] && valid[k] && !rd_in_hit[k])
        overrun_nxt[k] = 1'b1;
    end
  end

  always_comb begin
    status_word              = '0;
    status_word[C-1:0]       = valid;
    status_word[2*C-1:C]     = overrun;
    mask_word                = '0;
    mask_word[C-1:0]         = mask;
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < C; k++) begin
      if (offset == ADDR_W'(k))
        rd_mux = in_data[k];
      if (offset == ADDR_W'(C + k))
        rd_mux = out_data[k];
    end
    if (offset == STATUS_OFF)
      rd_mux = status_word;
    if (offset == MASK_OFF)
      rd_mux = mask_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_data  <= '0;
      out_data <= '0;
      valid    <= '0;
      overrun  <= '0;
      mask     <= '0;
      rd_data  <= '0;
      irq      <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < C; k++) begin
        if (gpi_we[k])
          in_data[k] <= gpi_ch[k];
        if (wr_out_hit[k])
          out_data[k] <= wr_data;
      end
      valid   <= valid_nxt;
      overrun <= overrun_nxt;
      if (mask_wr)
        mask <= wr_data[C-1:0];
      if (rd_hit)
        rd_data <= rd_mux;
      irq <= |(valid & mask);
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed vector bench for gpio_bank: a table of per-cycle stimulus with
// expected rd_data/gpo/irq after each edge, plus irq latency sequences.
module tb_gpio_bank;

  logic        clock;
  logic        reset;
  logic [31:0] gpi;
  logic [3:0]  gpi_we;
  logic [7:0]  mem_addr;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [31:0] gpo;
  logic        irq;

  int unsigned passed;
  int unsigned total;

  gpio_bank #(
    .DATA_W   (8),
    .CHANNELS (4),
    .ADDR_W   (8),
    .BASE_ADDR(8'hF0)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .gpi     (gpi),
    .gpi_we  (gpi_we),
    .mem_addr(mem_addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .gpo     (gpo),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  we;
    logic [31:0] gpi;
    logic [7:0]  addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        rd;
    logic [7:0]  e_rd;
    logic [31:0] e_gpo;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] we, input logic [31:0] g,
                     input logic [7:0] addr, input logic wr, input logic [7:0] wd,
                     input logic rd, input logic [7:0] e_rd, input logic [31:0] e_gpo,
                     input logic e_irq);
    vec_t v;
    v.rst = rst; v.we = we; v.gpi = g; v.addr = addr; v.wr = wr; v.wdata = wd;
    v.rd = rd; v.e_rd = e_rd; v.e_gpo = e_gpo; v.e_irq = e_irq;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [3:0] we, input logic [31:0] g,
                       input logic [7:0] addr, input logic wr, input logic [7:0] wd,
                       input logic rd);
    reset = rst; gpi_we = we; gpi = g; mem_addr = addr; wr_en = wr; wr_data = wd; rd_en = rd;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int unsigned cycles;
    passed = 0;
    total  = 0;
    drive(1'b1, 4'h0, 32'h0, 8'h00, 1'b0, 8'h00, 1'b0);

    //  rst we    gpi           addr   wr wdata  rd e_rd   e_gpo         irq
    add(1, 4'hF, 32'h44332211, 8'hF4, 1, 8'hFF, 0, 8'h00, 32'h00000000, 0); // 0 reset under traffic
    add(1, 4'hF, 32'h44332211, 8'hF4, 1, 8'hFF, 0, 8'h00, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h00, 32'h00000000, 0); // status after reset
    add(0, 4'h2, 32'h0000A500, 8'h00, 0, 8'h00, 0, 8'h00, 32'h00000000, 0); // capture ch1
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h02, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF1, 0, 8'h00, 1, 8'hA5, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h00, 32'h00000000, 0);
    add(0, 4'h1, 32'h00000011, 8'h00, 0, 8'h00, 0, 8'h00, 32'h00000000, 0); // 7 ch0 twice
    add(0, 4'h1, 32'h00000022, 8'h00, 0, 8'h00, 0, 8'h00, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h11, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 1, 8'h10, 0, 8'h11, 32'h00000000, 0); // W1C overrun0
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h01, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF0, 0, 8'h00, 1, 8'h22, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h00, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF9, 1, 8'h04, 0, 8'h00, 32'h00000000, 0); // 14 mask ch2
    add(0, 4'h4, 32'h00CC0000, 8'h00, 0, 8'h00, 0, 8'h00, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'h00, 0, 8'h00, 0, 8'h00, 32'h00000000, 1);
    add(0, 4'h0, 32'h00000000, 8'hF2, 0, 8'h00, 1, 8'hCC, 32'h00000000, 1);
    add(0, 4'h0, 32'h00000000, 8'h00, 0, 8'h00, 0, 8'hCC, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF9, 0, 8'h00, 1, 8'h04, 32'h00000000, 0);
    add(0, 4'h0, 32'h00000000, 8'hF5, 1, 8'h5A, 0, 8'h04, 32'h00005A00, 0); // 20 OUT1
    add(0, 4'h0, 32'h00000000, 8'hF7, 1, 8'h3C, 0, 8'h04, 32'h3C005A00, 0); // OUT3
    add(0, 4'h0, 32'h00000000, 8'hF7, 0, 8'h00, 1, 8'h3C, 32'h3C005A00, 0);
    add(0, 4'h1, 32'h00000055, 8'h00, 0, 8'h00, 0, 8'h3C, 32'h3C005A00, 0); // 23 ch0=55
    add(0, 4'h1, 32'h00000077, 8'hF0, 0, 8'h00, 1, 8'h55, 32'h3C005A00, 0); // read+capture
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h01, 32'h3C005A00, 0);
    add(0, 4'h0, 32'h00000000, 8'hF0, 0, 8'h00, 1, 8'h77, 32'h3C005A00, 0);
    add(0, 4'h0, 32'h00000000, 8'hFA, 1, 8'hFF, 1, 8'h77, 32'h3C005A00, 0); // out of window
    add(0, 4'h0, 32'h00000000, 8'hEF, 1, 8'hFF, 1, 8'h77, 32'h3C005A00, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h00, 32'h3C005A00, 0);
    add(0, 4'h0, 32'h00000000, 8'hF9, 0, 8'h00, 1, 8'h04, 32'h3C005A00, 0);
    add(0, 4'h0, 32'h00000000, 8'hF5, 1, 8'h99, 1, 8'h5A, 32'h3C009900, 0); // 31 rd+wr same addr
    add(0, 4'h0, 32'h00000000, 8'hF5, 0, 8'h00, 1, 8'h99, 32'h3C009900, 0);
    add(0, 4'h8, 32'h01000000, 8'h00, 0, 8'h00, 0, 8'h99, 32'h3C009900, 0); // 33 ch3 x3
    add(0, 4'h8, 32'h02000000, 8'h00, 0, 8'h00, 0, 8'h99, 32'h3C009900, 0);
    add(0, 4'h8, 32'h03000000, 8'hF8, 1, 8'h80, 0, 8'h99, 32'h3C009900, 0); // W1C vs set
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h88, 32'h3C009900, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 1, 8'h80, 0, 8'h88, 32'h3C009900, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h08, 32'h3C009900, 0);
    add(0, 4'h0, 32'h00000000, 8'hF3, 0, 8'h00, 1, 8'h03, 32'h3C009900, 0);
    add(0, 4'h0, 32'h00000000, 8'hF8, 0, 8'h00, 1, 8'h00, 32'h3C009900, 0);
    add(0, 4'h0, 32'h00000000, 8'hF1, 1, 8'hEE, 0, 8'h00, 32'h3C009900, 0); // 41 write IN1
    add(0, 4'h0, 32'h00000000, 8'hF1, 0, 8'h00, 1, 8'hA5, 32'h3C009900, 0);
    add(0, 4'h0, 32'h00000000, 8'hF9, 1, 8'hF4, 0, 8'hA5, 32'h3C009900, 0); // mask upper bits
    add(0, 4'h0, 32'h00000000, 8'hF9, 0, 8'h00, 1, 8'h04, 32'h3C009900, 0);
    add(1, 4'h0, 32'h00000000, 8'hF7, 0, 8'h00, 1, 8'h00, 32'h00000000, 0); // 45 reset mid-read

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].gpi, vecs[i].addr, vecs[i].wr,
            vecs[i].wdata, vecs[i].rd);
      step();
      check($sformatf("v%0d rd_data", i), {24'h0, rd_data}, {24'h0, vecs[i].e_rd});
      check($sformatf("v%0d gpo", i), gpo, vecs[i].e_gpo);
      check($sformatf("v%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].e_irq});
    end

    // irq latency: rises one edge after valid sets, falls one edge after it clears
    drive(1'b0, 4'h0, 32'h0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 4'h0, 32'h0, 8'hF9, 1'b1, 8'h02, 1'b0);
    step();
    drive(1'b0, 4'h2, 32'h00009600, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("irq_at_capture", {31'h0, irq}, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycles = 0;
    while (cycles < 8) begin
      step();
      cycles++;
      if (irq) break;
    end
    check("irq_rise_latency", cycles, 1);
    check("irq_high", {31'h0, irq}, 32'h1);
    drive(1'b0, 4'h0, 32'h0, 8'hF1, 1'b0, 8'h00, 1'b1);
    step();
    check("irq_read_rd_data", {24'h0, rd_data}, 32'h96);
    check("irq_at_read", {31'h0, irq}, 32'h1);
    drive(1'b0, 4'h0, 32'h0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycles = 0;
    while (cycles < 8) begin
      step();
      cycles++;
      if (!irq) break;
    end
    check("irq_fall_latency", cycles, 1);
    check("irq_low", {31'h0, irq}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
